// File: rtl/led_seq_ctrl_if.sv
// Raw board buttons in, LED pattern and sequencer status out.
interface led_seq_ctrl_if;
  logic       btn_mode;
  logic       btn_speed;
  logic       btn_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;

  modport master (output btn_mode, btn_speed, btn_pause,
                  input  led, mode, speed, paused);
  modport slave  (input  btn_mode, btn_speed, btn_pause,
                  output led, mode, speed, paused);
endinterface

// File: rtl/led_seq_ctrl.sv
// Debounced three-button sequencer driving a 4-LED running light; press-to-output is DEBOUNCE_CYC+3 edges.
// Define LED_SEQ_PING_EN to include PING mode and its direction register.
module led_seq_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned TICK_BASE    = 50_000_000
) (
  input logic           clk,
  input logic           rst_n,
  led_seq_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ROTL  = 2'b00,
    ROTR  = 2'b01,
    PING  = 2'b10,
    BLINK = 2'b11
  } mode_e;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {bus.btn_pause, bus.btn_speed, bus.btn_mode};

  // press[i] is registered alongside the debounced flip so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          deb[i]    <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic        mode_press;
  logic        speed_press;
  logic        pause_press;
  assign mode_press  = press[0];
  assign speed_press = press[1];
  assign pause_press = press[2];

  logic [3:0]  led_q, led_n;
  mode_e       mode_q, mode_n;
  logic [1:0]  speed_q, speed_n;
  logic        paused_q, paused_n;
  logic [31:0] cnt_q, cnt_n;
  logic [31:0] period;
  logic        tick;
`ifdef LED_SEQ_PING_EN
  logic        dir_right_q, dir_right_n;
`endif

  assign period = TICK_BASE << (2'd3 - speed_q);
  assign tick   = !paused_q && (cnt_q == period - 32'd1);

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      ROTL:    next_mode = ROTR;
`ifdef LED_SEQ_PING_EN
      ROTR:    next_mode = PING;
      PING:    next_mode = BLINK;
`else
      ROTR:    next_mode = BLINK;
`endif
      default: next_mode = ROTL;
    endcase
  endfunction

  always_comb begin
    led_n    = led_q;
    mode_n   = mode_q;
    speed_n  = speed_q;
    paused_n = paused_q;
    cnt_n    = cnt_q;
`ifdef LED_SEQ_PING_EN
    dir_right_n = dir_right_q;
`endif

    if (pause_press) paused_n = !paused_q;
    if (speed_press) speed_n = speed_q + 2'd1;

    if (mode_press || speed_press) cnt_n = '0;
    else if (tick)                 cnt_n = '0;
    else if (!paused_q)            cnt_n = cnt_q + 32'd1;

    // A mode load swallows a coincident tick.
    if (mode_press) begin
      mode_n = next_mode(mode_q);
      led_n  = (mode_n == BLINK) ? 4'b0101 : 4'b0001;
`ifdef LED_SEQ_PING_EN
      dir_right_n = 1'b0;
`endif
    end else if (tick) begin
      case (mode_q)
        ROTL: led_n = {led_q[2:0], led_q[3]};
        ROTR: led_n = {led_q[0], led_q[3:1]};
`ifdef LED_SEQ_PING_EN
        PING: begin
          if (!dir_right_q) begin
            if (led_q == 4'b1000) begin
              dir_right_n = 1'b1;
              led_n       = 4'b0100;
            end else begin
              led_n = {led_q[2:0], 1'b0};
            end
          end else begin
            if (led_q == 4'b0001) begin
              dir_right_n = 1'b0;
              led_n       = 4'b0010;
            end else begin
              led_n = {1'b0, led_q[3:1]};
            end
          end
        end
`endif
        default: led_n = ~led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q    <= 4'b0001;
      mode_q   <= ROTL;
      speed_q  <= 2'b01;
      paused_q <= 1'b0;
      cnt_q    <= '0;
`ifdef LED_SEQ_PING_EN
      dir_right_q <= 1'b0;
`endif
    end else begin
      led_q    <= led_n;
      mode_q   <= mode_n;
      speed_q  <= speed_n;
      paused_q <= paused_n;
      cnt_q    <= cnt_n;
`ifdef LED_SEQ_PING_EN
      dir_right_q <= dir_right_n;
`endif
    end
  end

  assign bus.led    = led_q;
  assign bus.mode   = mode_q;
  assign bus.speed  = speed_q;
  assign bus.paused = paused_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with DEBOUNCE_CYC=4, TICK_BASE=2 (P=8 at reset speed).
module tb_led_seq_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(
    .DEBOUNCE_CYC(4),
    .TICK_BASE   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [8:0] want;
    string      tag;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int at, input string tag, input logic [3:0] l,
                           input logic [1:0] m, input logic [1:0] s, input logic p);
    exp_t e;
    e.at   = at;
    e.want = {l, m, s, p};
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Advance one edge; compare every scoreboard entry due at this edge, then return at the negedge.
  task automatic next_cycle();
    logic [8:0] obs;
    exp_t       e;
    @(posedge clk);
    cyc++;
    #2;
    obs = {bus.led, bus.mode, bus.speed, bus.paused};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        e = sb[i];
        checks++;
        assert (obs === e.want) else begin
          errors++;
          $error("FAIL %s cycle %0d: led/mode/speed/paused got %b/%b/%b/%b want %b/%b/%b/%b",
                 e.tag, cyc, obs[8:5], obs[4:3], obs[2:1], obs[0],
                 e.want[8:5], e.want[4:3], e.want[2:1], e.want[0]);
        end
        sb.delete(i);
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       bus.btn_mode  = v;
      1:       bus.btn_speed = v;
      default: bus.btn_pause = v;
    endcase
  endtask

  task automatic press(input int idx, input int hold);
    set_btn(idx, 1'b1);
    repeat (hold) next_cycle();
    set_btn(idx, 1'b0);
  endtask

  int r, b, s, s2, s3, s4, e_step, f, c, m, k;
`ifdef LED_SEQ_PING_EN
  int m2;
`endif

  initial begin
    bus.btn_mode  = 1'b0;
    bus.btn_speed = 1'b0;
    bus.btn_pause = 1'b0;

    next_cycle();
    expect_at(cyc + 1, "reset_state", 4'b0001, 2'b00, 2'b01, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    r = cyc;

    // Free-running ROTL at P=8.
    expect_at(r + 7,  "rotl_hold",  4'b0001, 2'b00, 2'b01, 1'b0);
    expect_at(r + 8,  "rotl_s1",    4'b0010, 2'b00, 2'b01, 1'b0);
    expect_at(r + 15, "rotl_hold2", 4'b0010, 2'b00, 2'b01, 1'b0);
    expect_at(r + 16, "rotl_s2",    4'b0100, 2'b00, 2'b01, 1'b0);
    expect_at(r + 24, "rotl_s3",    4'b1000, 2'b00, 2'b01, 1'b0);
    expect_at(r + 32, "rotl_wrap",  4'b0001, 2'b00, 2'b01, 1'b0);
    wait_to(r + 32);

    // Three-cycle bounce on mode must be ignored.
    b = cyc;
    expect_at(b + 7, "bounce_nochg", 4'b0001, 2'b00, 2'b01, 1'b0);
    expect_at(b + 8, "bounce_step",  4'b0010, 2'b00, 2'b01, 1'b0);
    press(0, 3);
    wait_to(b + 16);

    // Speed 01->10: period 4, interval restarts at the press.
    s = cyc;
    expect_at(s + 7,  "spd10_load", 4'b0100, 2'b00, 2'b10, 1'b0);
    expect_at(s + 10, "spd10_hold", 4'b0100, 2'b00, 2'b10, 1'b0);
    expect_at(s + 11, "spd10_s1",   4'b1000, 2'b00, 2'b10, 1'b0);
    expect_at(s + 15, "spd10_s2",   4'b0001, 2'b00, 2'b10, 1'b0);
    press(1, 4);
    wait_to(s + 15);

    // Speed 10->11: period 2.
    s2 = cyc;
    expect_at(s2 + 4,  "spd11_pre",     4'b0010, 2'b00, 2'b10, 1'b0);
    expect_at(s2 + 7,  "spd11_load",    4'b0010, 2'b00, 2'b11, 1'b0);
    expect_at(s2 + 8,  "spd11_restart", 4'b0010, 2'b00, 2'b11, 1'b0);
    expect_at(s2 + 9,  "spd11_s1",      4'b0100, 2'b00, 2'b11, 1'b0);
    expect_at(s2 + 11, "spd11_s2",      4'b1000, 2'b00, 2'b11, 1'b0);
    press(1, 4);
    wait_to(s2 + 13);

    // Speed 11 wraps to 00: period 16.
    s3 = cyc;
    expect_at(s3 + 6,  "spd00_pre",     4'b1000, 2'b00, 2'b11, 1'b0);
    expect_at(s3 + 7,  "spd00_load",    4'b1000, 2'b00, 2'b00, 1'b0);
    expect_at(s3 + 8,  "spd00_restart", 4'b1000, 2'b00, 2'b00, 1'b0);
    expect_at(s3 + 22, "spd00_hold",    4'b1000, 2'b00, 2'b00, 1'b0);
    expect_at(s3 + 23, "spd00_s1",      4'b0001, 2'b00, 2'b00, 1'b0);
    press(1, 4);
    wait_to(s3 + 23);

    // Back to speed 01 (period 8).
    s4 = cyc;
    expect_at(s4 + 7,  "spd01_load", 4'b0001, 2'b00, 2'b01, 1'b0);
    expect_at(s4 + 14, "spd01_hold", 4'b0001, 2'b00, 2'b01, 1'b0);
    expect_at(s4 + 15, "spd01_s1",   4'b0010, 2'b00, 2'b01, 1'b0);
    press(1, 4);
    wait_to(s4 + 10);

    // Pause lands 2 edges after the step, freezing the count at 2; resume steps 6 edges later.
    e_step = s4 + 15;
    f      = e_step + 102;
    expect_at(e_step + 1,   "pause_pre",    4'b0010, 2'b00, 2'b01, 1'b0);
    expect_at(e_step + 2,   "pause_set",    4'b0010, 2'b00, 2'b01, 1'b1);
    expect_at(e_step + 8,   "pause_frozen", 4'b0010, 2'b00, 2'b01, 1'b1);
    expect_at(e_step + 101, "pause_long",   4'b0010, 2'b00, 2'b01, 1'b1);
    expect_at(f,            "resume_clr",   4'b0010, 2'b00, 2'b01, 1'b0);
    expect_at(f + 5,        "resume_hold",  4'b0010, 2'b00, 2'b01, 1'b0);
    expect_at(f + 6,        "resume_step",  4'b0100, 2'b00, 2'b01, 1'b0);
    press(2, 4);
    wait_to(f - 7);
    press(2, 4);
    wait_to(f + 6);

    // Mode held 10 cycles: ROTR loads 0001, then rotates right.
    c = cyc;
    expect_at(c + 6,  "mode1_pre",  4'b0100, 2'b00, 2'b01, 1'b0);
    expect_at(c + 7,  "mode1_load", 4'b0001, 2'b01, 2'b01, 1'b0);
    expect_at(c + 14, "rotr_hold",  4'b0001, 2'b01, 2'b01, 1'b0);
    expect_at(c + 15, "rotr_s1",    4'b1000, 2'b01, 2'b01, 1'b0);
    press(0, 10);
    wait_to(c + 16);

    // Second mode press lands on a tick cycle; the load wins.
    m = cyc;
    expect_at(m + 6, "mode2_pre", 4'b1000, 2'b01, 2'b01, 1'b0);
`ifdef LED_SEQ_PING_EN
    expect_at(m + 7,  "ping_load", 4'b0001, 2'b10, 2'b01, 1'b0);
    expect_at(m + 15, "ping_s1",   4'b0010, 2'b10, 2'b01, 1'b0);
    expect_at(m + 23, "ping_s2",   4'b0100, 2'b10, 2'b01, 1'b0);
    expect_at(m + 31, "ping_s3",   4'b1000, 2'b10, 2'b01, 1'b0);
    expect_at(m + 39, "ping_turnr",4'b0100, 2'b10, 2'b01, 1'b0);
    expect_at(m + 47, "ping_s5",   4'b0010, 2'b10, 2'b01, 1'b0);
    expect_at(m + 55, "ping_s6",   4'b0001, 2'b10, 2'b01, 1'b0);
    expect_at(m + 63, "ping_turnl",4'b0010, 2'b10, 2'b01, 1'b0);
    press(0, 4);
    wait_to(m + 63);
    m2 = cyc;
    expect_at(m2 + 6, "mode3_pre",  4'b0010, 2'b10, 2'b01, 1'b0);
    expect_at(m2 + 7, "blink_load", 4'b0101, 2'b11, 2'b01, 1'b0);
    press(0, 4);
    k = m2 + 7;
`else
    expect_at(m + 7, "blink_load", 4'b0101, 2'b11, 2'b01, 1'b0);
    press(0, 4);
    k = m + 7;
`endif
    wait_to(k);

    // BLINK toggles; pause coincides with a tick; then a one-cycle reset.
    expect_at(k + 7,  "blink_hold",   4'b0101, 2'b11, 2'b01, 1'b0);
    expect_at(k + 8,  "blink_s1",     4'b1010, 2'b11, 2'b01, 1'b0);
    expect_at(k + 15, "blink_hold2",  4'b1010, 2'b11, 2'b01, 1'b0);
    expect_at(k + 16, "blink_pause",  4'b0101, 2'b11, 2'b01, 1'b1);
    expect_at(k + 20, "blink_frozen", 4'b0101, 2'b11, 2'b01, 1'b1);
    expect_at(k + 21, "midrun_reset", 4'b0001, 2'b00, 2'b01, 1'b0);
    expect_at(k + 28, "post_rst_hold",4'b0001, 2'b00, 2'b01, 1'b0);
    expect_at(k + 29, "post_rst_s1",  4'b0010, 2'b00, 2'b01, 1'b0);
    wait_to(k + 9);
    press(2, 4);
    wait_to(k + 20);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    wait_to(k + 35);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries pending, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Button-driven sequencer for the 4-LED running-light datapath on the lab board. It debounces three push buttons and uses them to select a display mode, a step speed and a pause state. It generates the step tick and drives the LED pattern: rotate left, rotate right, ping-pong or blink. It sits between the raw board buttons and the LED pins and replaces the fixed switch and direction inputs with user-sequenced control.

## Interface
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles required to accept a button level change; minimum 2.
- TICK_BASE, 50_000_000: tick period in clk cycles at the fastest speed level.
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_mode  input  1  raw mode button, active-high, asynchronous.
- btn_speed  input  1  raw speed button, active-high, asynchronous.
- btn_pause  input  1  raw pause button, active-high, asynchronous.
- led  output  4  LED pattern, registered.
- mode  output  2  current mode: 00 ROTL, 01 ROTR, 10 PING, 11 BLINK.
- speed  output  2  speed level: 00 slowest … 11 fastest.
- paused  output  1  1 while stepping is frozen.

## Operation
- Button path, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the debounced state and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 with the levels still differing, the debounced state flips and the counter clears.
  - A press pulse is one cycle long and fires on a 0→1 transition of the debounced state. Release generates nothing.
- Tick generator:
  - Period P = TICK_BASE << (3 - speed): speed 00 gives 8×, 01 gives 4×, 10 gives 2×, 11 gives 1×.
  - Counter runs 0..P-1. Tick is asserted in the cycle the count equals P-1, and the count wraps to 0.
  - Width is 32 bits. TICK_BASE×8 must fit in 32 bits.
- Mode press:
  - Mode advances 00→01→10→11→00.
  - led is loaded with the mode's entry pattern: 0001 for ROTL/ROTR/PING (PING direction set to left), 0101 for BLINK.
  - The tick counter clears.
- Speed press: speed advances with wrap, 11→00, and the tick counter clears. led is unchanged.
- Pause press: toggles paused. While paused, the tick counter holds its value and no ticks occur. Mode and speed presses still take effect, and paused is unchanged by them.
- On tick, led updates according to mode:
  - ROTL: led ← {led[2:0], led[3]}.
  - ROTR: led ← {led[0], led[3:1]}.
  - PING moving left: shift left by one; if led == 1000, instead set direction right and led ← 0100.
  - PING moving right: shift right by one; if led == 0001, instead set direction left and led ← 0010.
  - BLINK: led ← ~led.
- Simultaneous events:
  - A mode press and a tick in the same cycle: the mode load wins and the tick is dropped.
  - Mode and speed presses in the same cycle: both apply, and the counter clears once.
  - A pause press together with other presses: all apply.
- Reset: led = 0001, mode = 00, speed = 01, paused = 0, PING direction left, tick counter 0, all debounced states 0, synchronizers 0. Reset applied mid-operation restores these values on the next edge, regardless of button levels.

## Timing
- Press pulse and state update latency from a raw rising edge held stable:
  - 2 cycles synchronization, then DEBOUNCE_CYC cycles debounce.
  - mode/speed/paused/led change on the following edge.
  - Total DEBOUNCE_CYC+3 edges.
- A raw level that is stable for fewer than DEBOUNCE_CYC synchronized cycles produces no pulse.
- led changes on the edge after the tick cycle. From reset or a counter clear, the first step occurs P cycles later; steps repeat every P cycles after that.
- On resume from pause, the counter continues from its held value. The next step occurs after the remaining P-1-count cycles plus 1.
- All outputs are registered. No combinational path exists from any button to any output.

## Configuration
- LED_SEQ_PING_EN defined: PING mode and its direction register exist, and the mode cycle is 00→01→10→11→00.
- LED_SEQ_PING_EN undefined: the mode cycle is 00→01→11→00, mode never equals 10, and the direction logic is removed. All other behaviour is identical.

## Test plan
All scenarios use DEBOUNCE_CYC=4 and TICK_BASE=2, giving P=8 at reset speed.
- Reset release, no presses: led steps 0001→0010→0100→1000→0001, one step every 8 cycles.
- Mode button bounce of 3 cycles: no change. Held for 10 cycles: mode=01 and led=0001 at edge 7 after the rise, then led=1000 after 8 more cycles.
- Press mode twice (LED_SEQ_PING_EN defined): led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. With the macro undefined, the same presses reach mode=11 with led=0101.
- Speed presses: 01→10 gives a period of 4, 11 gives 2, and a further press wraps to 00 with a period of 16. Each press restarts the step interval.
- Pause 3 cycles after a step: led is frozen for 100 cycles and paused=1. Unpause: the next step occurs 6 cycles after paused falls.
- BLINK mode: led toggles 0101↔1010 every P cycles. Assert rst_n=0 for 1 cycle mid-pattern: led=0001, mode=00, speed=01, paused=0 on the next edge.
